// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
// Holds the FSM state type, the invalid address code, and the write/busy state sets.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // One bit per state, indexed by the state encoding.
    localparam logic [7:0] WRITE_EN_SET =
        (8'd1 << LOAD_DATA) |
        (8'd1 << LOAD_PARITY) |
        (8'd1 << LOAD_AFTER_FULL);

    localparam logic [7:0] BUSY_SET =
        ~((8'd1 << DECODE_ADDRESS) |
          (8'd1 << LOAD_DATA));

    function automatic logic in_set(
        input logic [7:0]    set,
        input router_state_t st
    );
        return set[st];
    endfunction

endpackage

// File: rtl/router_fsm_stats.sv
// Saturating packet and drop counters for the router controller.
// Ports: clk, reset_in, pkt_done_i, abort_i -> pkt_count_o, drop_count_o.
module router_fsm_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             pkt_done_i,
    input  logic             abort_i,
    output logic [CNT_W-1:0] pkt_count_o,
    output logic [CNT_W-1:0] drop_count_o
);

    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        pkt_d  = pkt_q;
        drop_d = drop_q;
        if (pkt_done_i && (pkt_q != '1)) begin
            pkt_d = pkt_q + 1'b1;
        end
        if (abort_i && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            pkt_q  <= pkt_d;
            drop_q <= drop_d;
        end
    end

    assign pkt_count_o  = pkt_q;
    assign drop_count_o = drop_q;

endmodule

// File: rtl/router_fsm.sv
// Packet-level Moore controller for the 1x3 router (header, payload, full stall, parity).
// Ports: clk, reset_in, pkt_valid, data_in, fifo_full, fifo_empty_0..2, soft_rst_0..2,
// parity_done, low_pkt_valid -> detect_add, lfd/ld/laf/full_state, write_en_reg,
// rst_int_reg, busy, dest_addr; ROUTER_FSM_STATS_EN adds pkt_count, drop_count.
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_rst_0,
    input  logic              soft_rst_1,
    input  logic              soft_rst_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_en_reg,
    output logic              rst_int_reg,
    output logic              busy,
`ifdef ROUTER_FSM_STATS_EN
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  drop_count,
`endif
    output logic [ADDR_W-1:0] dest_addr
);

    router_state_t     state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;

    // Address 3 maps to a constant-0 slot so indexing never selects a real FIFO.
    logic [3:0] empty_v;
    logic [3:0] soft_v;
    logic       hdr_ok;
    logic       abort;

    assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_v  = {1'b0, soft_rst_2, soft_rst_1, soft_rst_0};
    assign hdr_ok  = pkt_valid && (data_in != ADDR_W'(ADDR_INVALID));

    // Only the FIFO this packet targets can abort it.
    assign abort = (state_q != DECODE_ADDRESS) && soft_v[dest_q];

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        if (abort) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_ok) begin
                        dest_d  = data_in;
                        state_d = empty_v[data_in] ? LOAD_FIRST_DATA
                                                   : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_v[dest_q]) begin
                        state_d = LOAD_FIRST_DATA;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = fifo_full ? FIFO_FULL_STATE
                                        : DECODE_ADDRESS;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q <= DECODE_ADDRESS;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    assign detect_add   = (state_q == DECODE_ADDRESS);
    assign lfd_state    = (state_q == LOAD_FIRST_DATA);
    assign ld_state     = (state_q == LOAD_DATA);
    assign laf_state    = (state_q == LOAD_AFTER_FULL);
    assign full_state   = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg  = (state_q == CHECK_PARITY_ERROR);
    assign write_en_reg = in_set(WRITE_EN_SET, state_q);
    assign busy         = in_set(BUSY_SET, state_q);
    assign dest_addr    = dest_q;

`ifdef ROUTER_FSM_STATS_EN
    logic pkt_done;

    // An abort out of CHECK_PARITY_ERROR is counted as a drop, not a packet.
    assign pkt_done = (state_q == CHECK_PARITY_ERROR) && !abort;

    router_fsm_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk          (clk),
        .reset_in     (reset_in),
        .pkt_done_i   (pkt_done),
        .abort_i      (abort),
        .pkt_count_o  (pkt_count),
        .drop_count_o (drop_count)
    );
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed packet scenarios then random traffic.
// A phase-level reference model predicts every output after each clock edge.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_rst_0, soft_rst_1, soft_rst_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, write_en_reg, rst_int_reg, busy;
    logic [1:0] dest_addr;
`ifdef ROUTER_FSM_STATS_EN
    logic [15:0] pkt_count, drop_count;
    logic [15:0] mpkt, mdrop;
`endif

    always #5 clk = ~clk;

    router_fsm dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_rst_0    (soft_rst_0),
        .soft_rst_1    (soft_rst_1),
        .soft_rst_2    (soft_rst_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_en_reg  (write_en_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
`ifdef ROUTER_FSM_STATS_EN
        .pkt_count     (pkt_count),
        .drop_count    (drop_count),
`endif
        .dest_addr     (dest_addr)
    );

    int vectors = 0;
    int miscompares = 0;

    // Phases: 0 idle/decode, 1 first data, 2 payload, 3 full stall,
    // 4 after full, 5 parity load, 6 parity check, 7 waiting for empty.
    int ph = 0;
    int mdest = 0;

    task automatic model_next();
        logic [2:0] emp;
        logic [2:0] srt;
        emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        srt = {soft_rst_2, soft_rst_1, soft_rst_0};
        if (reset_in) begin
            ph = 0;
            mdest = 0;
`ifdef ROUTER_FSM_STATS_EN
            mpkt = 0;
            mdrop = 0;
`endif
        end else if (ph != 0 && srt[mdest]) begin
            ph = 0;
`ifdef ROUTER_FSM_STATS_EN
            if (mdrop != 16'hffff) mdrop = mdrop + 1;
`endif
        end else begin
            case (ph)
                0: if (pkt_valid && data_in != 2'd3) begin
                    mdest = int'(data_in);
                    ph = emp[data_in] ? 1 : 7;
                end
                7: if (emp[mdest]) ph = 1;
                1: ph = 2;
                2: if (fifo_full) ph = 3;
                   else if (!pkt_valid) ph = 5;
                3: if (!fifo_full) ph = 4;
                4: if (parity_done) ph = 0;
                   else if (low_pkt_valid) ph = 5;
                   else ph = 2;
                5: ph = 6;
                6: begin
                    ph = fifo_full ? 3 : 0;
`ifdef ROUTER_FSM_STATS_EN
                    if (mpkt != 16'hffff) mpkt = mpkt + 1;
`endif
                end
                default: ph = 0;
            endcase
        end
    endtask

    function automatic logic [9:0] expected();
        logic [1:0] d;
        d = 2'(mdest);
        return {ph == 0, ph == 1, ph == 2, ph == 4, ph == 3,
                (ph == 2 || ph == 4 || ph == 5), ph == 6,
                !(ph == 0 || ph == 2), d};
    endfunction

    task automatic check(input string tag);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
               write_en_reg, rst_int_reg, busy, dest_addr};
        exp = expected();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s outputs=%b expected=%b", tag, obs, exp);
        end
`ifdef ROUTER_FSM_STATS_EN
        vectors++;
        assert ({pkt_count, drop_count} === {mpkt, mdrop}) else begin
            miscompares++;
            $error("FAIL %s_stats got=%h/%h expected=%h/%h",
                   tag, pkt_count, drop_count, mpkt, mdrop);
        end
`endif
    endtask

    task automatic expect_bit(input string tag, input logic obs,
                              input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s got=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_next();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        reset_in = 1'b1;
        pkt_valid = 1'b0;
        data_in = 2'd0;
        fifo_full = 1'b0;
        fifo_empty_0 = 1'b1;
        fifo_empty_1 = 1'b1;
        fifo_empty_2 = 1'b1;
        soft_rst_0 = 1'b0;
        soft_rst_1 = 1'b0;
        soft_rst_2 = 1'b0;
        parity_done = 1'b0;
        low_pkt_valid = 1'b0;

        step("reset0");
        step("reset1");
        expect_bit("rst_detect", detect_add, 1'b1);
        expect_bit("rst_busy", busy, 1'b0);
        expect_bit("rst_wr", write_en_reg, 1'b0);
        expect_bit("rst_dest0", dest_addr[0], 1'b0);
        reset_in = 1'b0;

        pkt_valid = 1'b1;
        data_in = 2'd1;
        step("hdr1");
        expect_bit("hdr1_lfd", lfd_state, 1'b1);
        expect_bit("hdr1_busy", busy, 1'b1);
        step("ld1");
        expect_bit("ld1_wr", write_en_reg, 1'b1);
        pkt_valid = 1'b0;
        step("par1");
        step("chk1");
        expect_bit("chk1_rst_int", rst_int_reg, 1'b1);
        step("dec1");

        pkt_valid = 1'b1;
        data_in = 2'd2;
        fifo_empty_2 = 1'b0;
        for (int i = 0; i < 5; i++) step("wait2");
        expect_bit("wait2_busy", busy, 1'b1);
        expect_bit("wait2_lfd", lfd_state, 1'b0);
        fifo_empty_2 = 1'b1;
        step("lfd2");
        step("ld2");

        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step("full2");
        expect_bit("full2_state", full_state, 1'b1);
        expect_bit("full2_wr", write_en_reg, 1'b0);
        fifo_full = 1'b0;
        pkt_valid = 1'b0;
        low_pkt_valid = 1'b1;
        step("laf2");
        expect_bit("laf2_state", laf_state, 1'b1);
        step("par2");
        low_pkt_valid = 1'b0;
        step("chk2");
        step("dec2");

        pkt_valid = 1'b1;
        data_in = 2'd0;
        fifo_empty_0 = 1'b0;
        step("wait0");
        soft_rst_1 = 1'b1;
        step("soft1_ign");
        expect_bit("soft1_busy", busy, 1'b1);
        soft_rst_1 = 1'b0;
        soft_rst_0 = 1'b1;
        data_in = 2'd3;
        step("soft0_abort");
        expect_bit("soft0_detect", detect_add, 1'b1);
        soft_rst_0 = 1'b0;
        fifo_empty_0 = 1'b1;

        for (int i = 0; i < 3; i++) step("bad_addr");
        expect_bit("bad_addr_detect", detect_add, 1'b1);

        for (int i = 0; i < 600; i++) begin
            reset_in = ($urandom_range(63) == 0);
            pkt_valid = ($urandom_range(3) != 0);
            data_in = 2'($urandom);
            fifo_full = ($urandom_range(3) == 0);
            fifo_empty_0 = 1'($urandom);
            fifo_empty_1 = 1'($urandom);
            fifo_empty_2 = 1'($urandom);
            soft_rst_0 = ($urandom_range(19) == 0);
            soft_rst_1 = ($urandom_range(19) == 0);
            soft_rst_2 = ($urandom_range(19) == 0);
            parity_done = ($urandom_range(3) == 0);
            low_pkt_valid = ($urandom_range(3) == 0);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
